// File: rtl/rf_pkg.sv
// Shared constants and helpers for the scoreboarded integer register file.
package rf_pkg;

  localparam int unsigned DATA_N_DEF = 32;
  localparam int unsigned SIZE_DEF   = 32;
  localparam int unsigned REG_ZERO   = 0;

  // Low bit of field k in a packed vector of equal-width fields.
  function automatic int unsigned slice_lo(input int unsigned k, input int unsigned width);
    return k * width;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending bits with flush > issue-set > write-clear priority, plus a popcount.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int unsigned SIZE   = SIZE_DEF,
  parameter int unsigned ADDR_W = $clog2(SIZE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic              flush,
  output logic [SIZE-1:0]   pend,
  output logic [ADDR_W:0]   pend_cnt
);

  logic [SIZE-1:0] r_pend;
  logic [SIZE-1:0] w_pend_d;
  logic [ADDR_W:0] w_cnt;

  always_comb begin
    w_pend_d = r_pend;
    if (flush) begin
      w_pend_d = '0;
    end else begin
      // Set applied after clear so a new producer supersedes the retiring one.
      if (wr_en) w_pend_d[w_addr] = 1'b0;
      if (issue_en) w_pend_d[issue_addr] = 1'b1;
    end
    w_pend_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
    end else begin
      r_pend <= w_pend_d;
    end
  end

  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < int'(SIZE); i++) begin
      w_cnt = w_cnt + (ADDR_W+1)'(r_pend[i]);
    end
  end

  assign pend     = r_pend;
  assign pend_cnt = w_cnt;

endmodule

// File: rtl/register_file_sb.sv
// Integer register file: NUM_RD combinational read ports, one write port, optional
// write-to-read bypass, scoreboard busy flags and a non-bypassed debug read port.
module register_file_sb
  import rf_pkg::*;
#(
  parameter int unsigned DATA_N = DATA_N_DEF,
  parameter int unsigned SIZE   = SIZE_DEF,
  parameter int unsigned ADDR_W = $clog2(SIZE),
  parameter int unsigned NUM_RD = 2,
  parameter bit          BYPASS = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        w_addr,
  input  logic [DATA_N-1:0]        w_data,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_addr,
  input  logic                     flush,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_N-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [ADDR_W-1:0]        dbg_addr,
  output logic [DATA_N-1:0]        dbg_data,
  output logic [ADDR_W:0]          pend_cnt
);

  logic [DATA_N-1:0] r_regs [SIZE];
  logic [SIZE-1:0]   w_pend;
  logic              w_wr_ok;

  assign w_wr_ok = wr_en && (w_addr != ADDR_W'(REG_ZERO));

  // Entry 0 is never written, so it holds its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(SIZE); i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_regs[w_addr] <= w_data;
    end
  end

  rf_scoreboard #(
    .SIZE   (SIZE),
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .w_addr     (w_addr),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .flush      (flush),
    .pend       (w_pend),
    .pend_cnt   (pend_cnt)
  );

  for (genvar k = 0; k < int'(NUM_RD); k++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic              w_fwd;

    assign w_ra  = rd_addr[slice_lo(k, ADDR_W) +: ADDR_W];
    assign w_fwd = BYPASS && w_wr_ok && (w_addr == w_ra);

    assign rd_data[slice_lo(k, DATA_N) +: DATA_N] = w_fwd ? w_data : r_regs[w_ra];
    assign rd_busy[k] = w_pend[w_ra] && !w_fwd;
  end

  assign dbg_data = r_regs[dbg_addr];

endmodule

// File: tb/tb_register_file_sb.sv
// Directed plus randomized bench for register_file_sb, checking BYPASS=1 and BYPASS=0 instances.
module tb_register_file_sb;

  localparam int DW = 32;
  localparam int SZ = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           wr_en;
  logic [AW-1:0]  w_addr;
  logic [DW-1:0]  w_data;
  logic           issue_en;
  logic [AW-1:0]  issue_addr;
  logic           flush;
  logic [NR*AW-1:0] rd_addr;
  logic [AW-1:0]  dbg_addr;

  logic [NR*DW-1:0] rd_data_b, rd_data_n;
  logic [NR-1:0]    rd_busy_b, rd_busy_n;
  logic [DW-1:0]    dbg_data_b, dbg_data_n;
  logic [AW:0]      pend_cnt_b, pend_cnt_n;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] m_regs [SZ];
  bit            m_pend [SZ];

  always #5 clk = ~clk;

  register_file_sb #(.DATA_N(DW), .SIZE(SZ), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .w_addr(w_addr), .w_data(w_data),
    .issue_en(issue_en), .issue_addr(issue_addr), .flush(flush), .rd_addr(rd_addr),
    .rd_data(rd_data_b), .rd_busy(rd_busy_b), .dbg_addr(dbg_addr), .dbg_data(dbg_data_b),
    .pend_cnt(pend_cnt_b)
  );

  register_file_sb #(.DATA_N(DW), .SIZE(SZ), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .w_addr(w_addr), .w_data(w_data),
    .issue_en(issue_en), .issue_addr(issue_addr), .flush(flush), .rd_addr(rd_addr),
    .rd_data(rd_data_n), .rd_busy(rd_busy_n), .dbg_addr(dbg_addr), .dbg_data(dbg_data_n),
    .pend_cnt(pend_cnt_n)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < SZ; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 1'b0;
    end
  endtask

  // Architectural effect of one clock edge, from the current input values.
  task automatic model_edge();
    if (wr_en && w_addr != 0) m_regs[w_addr] = w_data;
    for (int i = 1; i < SZ; i++) begin
      if (flush) m_pend[i] = 1'b0;
      else if (issue_en && issue_addr == AW'(i)) m_pend[i] = 1'b1;
      else if (wr_en && w_addr == AW'(i)) m_pend[i] = 1'b0;
    end
  endtask

  function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a, input bit byp);
    if (byp && wr_en && w_addr == a && a != '0) return w_data;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a, input bit byp);
    if (byp && wr_en && w_addr == a && a != '0) return 1'b0;
    return m_pend[a];
  endfunction

  function automatic int exp_cnt();
    int n = 0;
    for (int i = 0; i < SZ; i++) n += int'(m_pend[i]);
    return n;
  endfunction

  task automatic check_all();
    logic [AW-1:0] a;
    for (int k = 0; k < NR; k++) begin
      a = rd_addr[k*AW +: AW];
      check($sformatf("rd_data%0d_byp a=%0d", k, a), 64'(rd_data_b[k*DW +: DW]), 64'(exp_data(a, 1'b1)));
      check($sformatf("rd_data%0d_nob a=%0d", k, a), 64'(rd_data_n[k*DW +: DW]), 64'(exp_data(a, 1'b0)));
      check($sformatf("rd_busy%0d_byp a=%0d", k, a), 64'(rd_busy_b[k]), 64'(exp_busy(a, 1'b1)));
      check($sformatf("rd_busy%0d_nob a=%0d", k, a), 64'(rd_busy_n[k]), 64'(exp_busy(a, 1'b0)));
    end
    check("dbg_data_byp", 64'(dbg_data_b), 64'(m_regs[dbg_addr]));
    check("dbg_data_nob", 64'(dbg_data_n), 64'(m_regs[dbg_addr]));
    check("pend_cnt_byp", 64'(pend_cnt_b), 64'(exp_cnt()));
    check("pend_cnt_nob", 64'(pend_cnt_n), 64'(exp_cnt()));
  endtask

  // Called just after a negedge with inputs set: check, clock, update model, return at negedge.
  task automatic tick();
    #1 check_all();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    wr_en = 1'b0; issue_en = 1'b0; flush = 1'b0;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en = 1'b1; w_addr = a; w_data = d;
  endtask

  task automatic iss(input logic [AW-1:0] a);
    issue_en = 1'b1; issue_addr = a;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    w_addr = '0; w_data = '0; issue_addr = '0; rd_addr = '0; dbg_addr = '0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Populate state, then pulse reset asynchronously between edges.
    wr(5'd12, 32'hA5A5_0001); iss(5'd13); tick(); idle();
    #2 rst_n = 1'b0;
    model_reset();
    set_rd(5'd12, 5'd13); dbg_addr = 5'd12;
    #1 check_all();
    check("rst_pend_cnt", 64'(pend_cnt_b), 64'd0);
    check("rst_rd_data0", 64'(rd_data_b[DW-1:0]), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Write x5, same-cycle and next-cycle reads.
    wr(5'd5, 32'hDEAD_BEEF); set_rd(5'd5, 5'd5);
    #1 check("byp_same_cycle", 64'(rd_data_b[DW-1:0]), 64'hDEAD_BEEF);
    check("nob_same_cycle", 64'(rd_data_n[DW-1:0]), 64'd0);
    tick(); idle();
    #1 check("rd0_after_wr", 64'(rd_data_b[DW-1:0]), 64'hDEAD_BEEF);
    check("rd1_after_wr", 64'(rd_data_b[2*DW-1:DW]), 64'hDEAD_BEEF);

    // x0 protection.
    wr(5'd0, 32'h1234); iss(5'd0); set_rd(5'd0, 5'd0); dbg_addr = 5'd0;
    #1 check("x0_no_bypass", 64'(rd_data_b[DW-1:0]), 64'd0);
    tick(); idle();
    #1 check("x0_rd", 64'(rd_data_b[DW-1:0]), 64'd0);
    check("x0_busy", 64'(rd_busy_b), 64'd0);
    check("x0_cnt", 64'(pend_cnt_b), 64'd0);
    check("x0_dbg", 64'(dbg_data_b), 64'd0);

    // Scoreboard set and bypassed clear.
    iss(5'd7); tick(); idle(); set_rd(5'd7, 5'd0);
    #1 check("x7_busy", 64'(rd_busy_b[0]), 64'd1);
    check("x7_cnt", 64'(pend_cnt_b), 64'd1);
    wr(5'd7, 32'h42);
    #1 check("x7_busy_byp", 64'(rd_busy_b[0]), 64'd0);
    check("x7_busy_nob", 64'(rd_busy_n[0]), 64'd1);
    check("x7_data_byp", 64'(rd_data_b[DW-1:0]), 64'h42);
    tick(); idle();
    #1 check("x7_cnt_clear", 64'(pend_cnt_b), 64'd0);

    // Issue and write to the same index in one cycle.
    iss(5'd9); wr(5'd9, 32'h10); set_rd(5'd9, 5'd9);
    #1 check("x9_coll_data", 64'(rd_data_b[DW-1:0]), 64'h10);
    check("x9_coll_busy", 64'(rd_busy_b[0]), 64'd0);
    tick(); idle();
    #1 check("x9_data", 64'(rd_data_b[DW-1:0]), 64'h10);
    check("x9_busy", 64'(rd_busy_b[1]), 64'd1);

    // Flush beats a same-cycle issue.
    iss(5'd3); tick(); iss(5'd4); tick(); idle();
    flush = 1'b1; iss(5'd6); tick(); idle();
    #1 check("flush_cnt", 64'(pend_cnt_b), 64'd0);

    // Reset across an edge with a write in flight.
    iss(5'd2); tick(); iss(5'd3); tick(); iss(5'd4); tick(); idle();
    wr(5'd8, 32'h55); set_rd(5'd8, 5'd2);
    #1 rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1 idle();
    #1 check_all();
    check("rst_x8", 64'(rd_data_b[DW-1:0]), 64'd0);
    check("rst_cnt", 64'(pend_cnt_b), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic, biased to a few indices to force collisions.
    for (int it = 0; it < 600; it++) begin
      wr_en      = 1'($urandom_range(0, 1));
      w_addr     = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
      w_data     = $urandom;
      issue_en   = 1'($urandom_range(0, 1));
      issue_addr = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
      flush      = ($urandom_range(0, 15) == 0);
      set_rd(AW'($urandom_range(0, 8)), AW'($urandom_range(0, 8)));
      dbg_addr   = AW'($urandom_range(0, 31));
      if ($urandom_range(0, 99) == 0) begin
        #2 rst_n = 1'b0;
        model_reset();
        #1 check_all();
        rst_n = 1'b1;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
